if_stage: RTL and testbench

Instruction-fetch stage that owns the program counter and drives the word address of the combinational instruction ROM (64 x 32-bit, word-indexed). It samples the ROM output into a fetch/decode pipeline register and presents it to decode through a valid/ready handshake. It also accepts branch/jump redirects from execute, detects misaligned and out-of-range fetch addresses, and counts delivered instructions.

---
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// hands fetched words to decode over a valid/ready handshake.
module if_stage #(
   parameter int unsigned    N          = 64,
   parameter int unsigned    INSTR_W    = 32,
   parameter logic [N-1:0]   RESET_PC   = '0,
   parameter int unsigned    IMEM_WORDS = 64
) (
   input  logic               clk,
   input  logic               reset,
   output logic [5:0]         imem_addr,
   input  logic [INSTR_W-1:0] imem_q,
   input  logic               redirect_valid,
   input  logic [N-1:0]       redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [N-1:0]       if_pc,
   output logic               fault,
   output logic [N-1:0]       fault_pc,
   output logic [31:0]        fetch_count
);

   localparam logic [N-1:0] IMEM_BYTES = N'(4 * IMEM_WORDS);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t       state;
   logic [N-1:0] pc;
   logic         load;
   logic         redirect_bad;

   assign imem_addr    = pc[7:2];
   assign load         = !if_valid || if_ready;
   assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= IMEM_BYTES);

   // Redirect beats fetch; a transfer in the redirect cycle still counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         fault       <= 1'b0;
         fault_pc    <= '0;
         fetch_count <= '0;
      end else begin
         if (if_valid && if_ready)
            fetch_count <= fetch_count + 32'd1;

         unique case (state)
            BOOT: begin
               state <= RUN;
               if (redirect_valid) begin
                  if (redirect_bad) begin
                     state    <= FAULT;
                     fault    <= 1'b1;
                     fault_pc <= redirect_pc;
                  end else begin
                     pc <= redirect_pc;
                  end
               end
            end
            RUN: begin
               if (redirect_valid) begin
                  if_valid <= 1'b0;
                  if (redirect_bad) begin
                     state    <= FAULT;
                     fault    <= 1'b1;
                     fault_pc <= redirect_pc;
                  end else begin
                     pc <= redirect_pc;
                  end
               end else if (load && (pc >= IMEM_BYTES)) begin
                  state    <= FAULT;
                  fault    <= 1'b1;
                  fault_pc <= pc;
                  if_valid <= 1'b0;
               end else if (load) begin
                  if_instr <= imem_q;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  pc       <= pc + N'(4);
               end
            end
            FAULT: begin
               if_valid <= 1'b0;
            end
            default: begin
               state    <= FAULT;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a scoreboard of expected (pc, instr)
// pairs is filled when fetch is steered and drained as decode accepts.
module tb_if_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [31:0] imem_q;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        fault;
   logic [63:0] fault_pc;
   logic [31:0] fetch_count;

   logic [31:0] rom [64];
   exp_t        sbq [$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_count;

   always #5 clk = ~clk;

   assign imem_q = rom[imem_addr];

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .fault          (fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   // Expected fetch stream starting at a byte address.
   task automatic push_seq(input logic [63:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc    = start + 64'(4 * i);
         e.instr = rom[e.pc[7:2]];
         sbq.push_back(e);
      end
   endtask

   // Drain n transfers, one per cycle, checking each against the scoreboard.
   task automatic consume(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: scoreboard has no entry, if_pc=%h", if_pc);
         end else begin
            e = sbq.pop_front();
            checks++;
            if (if_valid !== 1'b1) begin
               failures++;
               $display("FAIL xfer_valid: got %b want 1 (pc %h)", if_valid, e.pc);
            end
            checks++;
            if (if_pc !== e.pc) begin
               failures++;
               $display("FAIL xfer_pc: got %h want %h", if_pc, e.pc);
            end
            checks++;
            if (if_instr !== e.instr) begin
               failures++;
               $display("FAIL xfer_instr: got %h want %h (pc %h)", if_instr, e.instr, e.pc);
            end
            checks++;
            if (fetch_count !== exp_count) begin
               failures++;
               $display("FAIL xfer_count: got %0d want %0d", fetch_count, exp_count);
            end
         end
         if (if_ready) exp_count = exp_count + 32'd1;
         @(negedge clk);
      end
   endtask

   // Reset, check reset state, release; returns at the negedge where the
   // first instruction should be visible.
   task automatic test_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      sbq.delete();
      @(negedge clk);
      exp_count = '0;
      checks++;
      if (if_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b fault=%b count=%0d want 0/0/0",
                  if_valid, fault, fetch_count);
      end
      checks++;
      if (if_pc !== 64'd0 || if_instr !== 32'd0 || fault_pc !== 64'd0 || imem_addr !== 6'd0) begin
         failures++;
         $display("FAIL reset_regs: pc=%h instr=%h fault_pc=%h addr=%0d want zeros",
                  if_pc, if_instr, fault_pc, imem_addr);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_bubble: if_valid=%b want 0", if_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_sequential();
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 7);
      consume(7);
   endtask

   task automatic test_backpressure();
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 4);
      consume(1);
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 64'h4 || if_instr !== 32'h00000533) begin
            failures++;
            $display("FAIL stall_hold: valid=%b pc=%h instr=%h want 1/4/00000533",
                     if_valid, if_pc, if_instr);
         end
         checks++;
         if (imem_addr !== 6'd2 || fetch_count !== exp_count) begin
            failures++;
            $display("FAIL stall_frozen: addr=%0d count=%0d want 2/%0d",
                     imem_addr, fetch_count, exp_count);
         end
      end
      if_ready = 1'b1;
      consume(3);
   endtask

   task automatic test_redirect();
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 5);
      consume(5);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 64'h14) begin
         failures++;
         $display("FAIL pre_redirect: valid=%b pc=%h want 1/14", if_valid, if_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8;
      exp_count      = exp_count + 32'd1;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0 || fetch_count !== exp_count) begin
         failures++;
         $display("FAIL redirect_flush: valid=%b count=%0d want 0/%0d",
                  if_valid, fetch_count, exp_count);
      end
      @(negedge clk);
      push_seq(64'h8, 3);
      consume(3);
   endtask

   task automatic test_fault_misaligned();
      // Continues from the running stream left by test_redirect.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6;
      if (if_valid) exp_count = exp_count + 32'd1;
      @(negedge clk);
      redirect_pc = 64'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fault !== 1'b1 || fault_pc !== 64'h6 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_sticky: fault=%b fault_pc=%h valid=%b want 1/6/0",
                     fault, fault_pc, if_valid);
         end
         @(negedge clk);
      end
      redirect_valid = 1'b0;
      checks++;
      if (fetch_count !== exp_count) begin
         failures++;
         $display("FAIL fault_count: got %0d want %0d", fetch_count, exp_count);
      end
      test_reset();
      push_seq(64'h0, 3);
      consume(3);
   endtask

   task automatic test_out_of_range();
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'hF8;
      consume(1);
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
         failures++;
         $display("FAIL oor_bubble: if_valid=%b want 0", if_valid);
      end
      @(negedge clk);
      push_seq(64'hF8, 2);
      consume(2);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (fault !== 1'b1 || fault_pc !== 64'h100 || if_valid !== 1'b0 ||
             fetch_count !== exp_count) begin
            failures++;
            $display("FAIL oor_fault: fault=%b fault_pc=%h valid=%b count=%0d want 1/100/0/%0d",
                     fault, fault_pc, if_valid, fetch_count, exp_count);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_handshake();
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 2);
      consume(2);
      if_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 64'h8) begin
         failures++;
         $display("FAIL mid_stall: valid=%b pc=%h want 1/8", if_valid, if_pc);
      end
      if_ready = 1'b1;
      test_reset();
      push_seq(64'h0, 7);
      consume(7);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = '0;
      rom[0] = 32'h0ff00593;
      rom[1] = 32'h00000533;
      rom[2] = 32'h00150513;
      rom[3] = 32'h00050513;
      rom[4] = 32'h00a03023;
      rom[5] = 32'hfeb51ae3;
      rom[6] = 32'hfe0006e3;
      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      exp_count      = '0;
      @(negedge clk);

      test_sequential();
      test_backpressure();
      test_redirect();
      test_fault_misaligned();
      test_out_of_range();
      test_reset_mid_handshake();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
